// File: rtl/enoc_switch_allocator.sv
// enoc_switch_allocator: per-output round-robin switch allocator with
// wormhole locking. Grants are combinational from the current requests and
// the registered per-output state (ptr, lock, owner).
module enoc_switch_allocator #(
    parameter int M = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [0:M-1][0:M-1] i_output_req,
    input  logic [0:M-1]        i_tail,
    input  logic [0:M-1]        i_output_en,
    output logic [0:M-1][0:M-1] o_output_grant,
    output logic [0:M-1]        o_input_grant,
    output logic [0:M-1]        o_output_locked
);
    localparam int PW = (M > 1) ? $clog2(M) : 1;

    // req_t[j][i] = i_output_req[i][j]; gnt_t[i][j] = o_output_grant[j][i]
    logic [0:M-1][0:M-1] req_t;
    logic [0:M-1][0:M-1] gnt_t;

    for (genvar i = 0; i < M; i++) begin : g_in
        for (genvar j = 0; j < M; j++) begin : g_x
            assign req_t[j][i] = i_output_req[i][j];
            assign gnt_t[i][j] = o_output_grant[j][i];
        end
        // Requests are onehot0, so at most one output grants this input.
        assign o_input_grant[i] = |gnt_t[i];
    end

    for (genvar j = 0; j < M; j++) begin : g_out
        logic [PW-1:0] ptr_q;
        logic [PW-1:0] owner_q;
        logic          lock_q;
        logic [PW-1:0] cand;
        logic [PW-1:0] idx;
        logic [PW-1:0] win;
        logic [PW-1:0] ptr_next;
        logic          found;
        logic          hit;

        // Round-robin search from ptr; a locked output only serves its owner.
        always_comb begin
            found = 1'b0;
            cand  = ptr_q;
            idx   = ptr_q;
            for (int unsigned k = 0; k < M; k++) begin
                idx = PW'((32'(ptr_q) + k) % 32'(M));
                if (!found && req_t[j][idx]) begin
                    found = 1'b1;
                    cand  = idx;
                end
            end
            if (lock_q) begin
                win = owner_q;
                hit = req_t[j][owner_q] & i_output_en[j];
            end else begin
                win = cand;
                hit = found & i_output_en[j];
            end
        end

        assign ptr_next = (win == PW'(M - 1)) ? '0 : win + 1'b1;

        for (genvar i = 0; i < M; i++) begin : g_gnt
            assign o_output_grant[j][i] = reset_n & hit & (win == PW'(i));
        end
        assign o_output_locked[j] = reset_n & lock_q;

        // Head grants move the pointer and may lock; tail grants release.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ptr_q   <= '0;
                owner_q <= '0;
                lock_q  <= 1'b0;
            end else if (hit) begin
                if (lock_q) begin
                    if (i_tail[win]) begin
                        lock_q <= 1'b0;
                    end
                end else begin
                    ptr_q <= ptr_next;
                    if (!i_tail[win]) begin
                        lock_q  <= 1'b1;
                        owner_q <= win;
                    end
                end
            end
        end
    end

endmodule
